// File: rtl/ddr_weight_reader.sv
// ddr_weight_reader: splits a byte-length DDR read into credit-limited bursts and buffers beats in a FWFT FIFO
module ddr_weight_reader #(
  parameter int DDR_ADDR_LEN = 32,
  parameter int DDR_DATA_LEN = 256,
  parameter int SINGLE_LEN = 24,
  parameter int MAX_BURST = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          conf,
  input  logic [DDR_ADDR_LEN-1:0]       ddr_st_addr,
  input  logic [SINGLE_LEN-1:0]         ddr_len,
  output logic [DDR_ADDR_LEN-1:0]       rd_addr,
  output logic [7:0]                    rd_burst_len,
  output logic                          rd_addr_valid,
  input  logic                          rd_addr_ready,
  input  logic [DDR_DATA_LEN-1:0]       rd_data,
  input  logic                          rd_data_valid,
  input  logic                          rd_data_last,
  output logic                          rd_data_ready,
  output logic                          fifo_empty,
  input  logic                          fifo_req,
  output logic [DDR_DATA_LEN-1:0]       fifo_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          idle,
  output logic                          done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic [1:0] {IDLE, CALC, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  logic [DDR_ADDR_LEN-1:0] addr_q, addr_d;
  logic [SINGLE_LEN-1:0] remain_q, remain_d, total, b4k, cap, bl_c;
  logic [7:0] blm1_q, blm1_d;
  logic [CW-1:0] reserved_q, reserved_d, count_q, count_d, credit;
  logic [OW-1:0] outst_q, outst_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic valid_q, valid_d, idle_q, idle_d, done_q, done_d;
  logic in_valid_q, in_valid_d, in_last_q, in_last_d;
  logic [DDR_DATA_LEN-1:0] in_data_q, in_data_d;
  logic [DDR_DATA_LEN-1:0] mem [FIFO_DEPTH];
  logic [8:0] bl;
  logic hs, push, pop, issue_ok;
  always_comb begin
    total = SINGLE_LEN'(ddr_len[SINGLE_LEN-1:5]) + SINGLE_LEN'(|ddr_len[4:0]);
    b4k = SINGLE_LEN'(8'd128 - {1'b0, addr_q[11:5]});
    cap = (b4k < SINGLE_LEN'(MAX_BURST)) ? b4k : SINGLE_LEN'(MAX_BURST);
    bl_c = (remain_q < cap) ? remain_q : cap;
    bl = {1'b0, blm1_q} + 9'd1;
    credit = CW'(FIFO_DEPTH) - count_q - reserved_q;
    issue_ok = (32'(credit) >= 32'(bl)) && (32'(outst_q) < 32'(MAX_OUTSTANDING));
    hs = valid_q && rd_addr_ready;
    push = in_valid_q;
    pop = fifo_req && (count_q != '0);
    state_d = state_q;
    addr_d = addr_q;
    remain_d = remain_q;
    blm1_d = blm1_q;
    valid_d = 1'b0;
    idle_d = idle_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (conf) begin
        addr_d = ddr_st_addr;
        remain_d = total;
        done_d = (total == '0);
        idle_d = (total == '0);
        state_d = (total == '0) ? IDLE : CALC;
      end
      CALC: begin
        blm1_d = 8'(bl_c - SINGLE_LEN'(1));
        state_d = ISSUE;
      end
      ISSUE: begin
        valid_d = !hs && (valid_q || issue_ok);
        if (hs) begin
          addr_d = addr_q + DDR_ADDR_LEN'({bl, 5'b0});
          remain_d = remain_q - SINGLE_LEN'(bl);
          state_d = (remain_q == SINGLE_LEN'(bl)) ? WAIT : CALC;
        end
      end
      WAIT: if (reserved_q == '0) begin
        done_d = 1'b1;
        idle_d = 1'b1;
        state_d = IDLE;
      end
    endcase
    reserved_d = reserved_q + (hs ? CW'(bl) : '0) - CW'(push);
    outst_d = outst_q + OW'(hs) - OW'(push && in_last_q);
    count_d = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    in_valid_d = rd_data_valid && (state_q != IDLE);
    in_last_d = rd_data_last;
    in_data_d = rd_data;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      remain_q <= '0;
      blm1_q <= '0;
      valid_q <= 1'b0;
      idle_q <= 1'b1;
      done_q <= 1'b0;
      reserved_q <= '0;
      outst_q <= '0;
      count_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      in_valid_q <= 1'b0;
      in_last_q <= 1'b0;
      in_data_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      remain_q <= remain_d;
      blm1_q <= blm1_d;
      valid_q <= valid_d;
      idle_q <= idle_d;
      done_q <= done_d;
      reserved_q <= reserved_d;
      outst_q <= outst_d;
      count_q <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      in_valid_q <= in_valid_d;
      in_last_q <= in_last_d;
      in_data_q <= in_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data_q;
  end
  assign rd_addr = addr_q;
  assign rd_burst_len = blm1_q;
  assign rd_addr_valid = valid_q;
  assign rd_data_ready = 1'b1;
  assign fifo_empty = (count_q == '0);
  assign fifo_data = fifo_empty ? '0 : mem[rd_ptr_q];
  assign fifo_count = count_q;
  assign idle = idle_q;
  assign done = done_q;
endmodule

// File: tb/tb_ddr_weight_reader.sv
// tb_ddr_weight_reader: directed bench with a simple in-order DDR responder and FIFO pop logger
module tb_ddr_weight_reader;
  logic clk, rst_n, conf;
  logic [31:0] ddr_st_addr;
  logic [23:0] ddr_len;
  logic [31:0] rd_addr;
  logic [7:0] rd_burst_len;
  logic rd_addr_valid, rd_addr_ready;
  logic [255:0] rd_data;
  logic rd_data_valid, rd_data_last, rd_data_ready;
  logic fifo_empty, fifo_req;
  logic [255:0] fifo_data;
  logic [6:0] fifo_count;
  logic idle, done;
  int n_chk = 0, n_fail = 0;
  int beats_sent = 0, done_cnt = 0, valid_cnt = 0;
  logic mem_en = 1'b1;
  logic [32:0] beat_q[$];
  logic [31:0] req_addr[$];
  logic [7:0] req_len[$];
  logic [31:0] pop_log[$];
  ddr_weight_reader dut (
    .clk(clk), .rst_n(rst_n), .conf(conf), .ddr_st_addr(ddr_st_addr), .ddr_len(ddr_len),
    .rd_addr(rd_addr), .rd_burst_len(rd_burst_len), .rd_addr_valid(rd_addr_valid),
    .rd_addr_ready(rd_addr_ready), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .rd_data_last(rd_data_last), .rd_data_ready(rd_data_ready), .fifo_empty(fifo_empty),
    .fifo_req(fifo_req), .fifo_data(fifo_data), .fifo_count(fifo_count), .idle(idle), .done(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    logic [32:0] b;
    rd_data_valid = 1'b0;
    rd_data_last = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      if (mem_en && beat_q.size() > 0) begin
        b = beat_q.pop_front();
        rd_data_valid = 1'b1;
        rd_data = 256'(b[31:0]);
        rd_data_last = b[32];
        beats_sent++;
      end else begin
        rd_data_valid = 1'b0;
        rd_data_last = 1'b0;
      end
      #4;
      if (rd_addr_valid) valid_cnt++;
      if (rd_addr_valid && rd_addr_ready) begin
        req_addr.push_back(rd_addr);
        req_len.push_back(rd_burst_len);
        for (int i = 0; i <= int'(rd_burst_len); i++)
          beat_q.push_back({i == int'(rd_burst_len), rd_addr + 32'(32 * i)});
      end
      if (fifo_req && !fifo_empty) pop_log.push_back(fifo_data[31:0]);
      if (done) done_cnt++;
    end
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_req(input string tag, input int idx, input logic [31:0] a, input logic [7:0] l);
    chk({tag, "_addr"}, idx < req_addr.size() ? req_addr[idx] : 32'hDEADBEEF, a);
    chk({tag, "_len"}, idx < req_len.size() ? 64'(req_len[idx]) : 64'hDEAD, l);
  endtask
  task automatic chk_pops(input string tag, input int n, input logic [31:0] st);
    int errs = 0;
    chk({tag, "_npop"}, pop_log.size(), n);
    foreach (pop_log[k]) if (pop_log[k] !== st + 32'(32 * k)) errs++;
    chk({tag, "_order"}, errs, 0);
  endtask
  task automatic start(input logic [31:0] a, input logic [23:0] l);
    ddr_st_addr = a;
    ddr_len = l;
    conf = 1'b1;
    tick();
    conf = 1'b0;
  endtask
  task automatic wait_done(input int d0, input string tag);
    for (int i = 0; i < 1000 && done_cnt == d0; i++) tick();
    chk(tag, done_cnt > d0, 1);
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && !(fifo_empty && beat_q.size() == 0); i++) tick();
    repeat (3) tick();
  endtask
  task automatic clear();
    req_addr.delete();
    req_len.delete();
    pop_log.delete();
  endtask
  initial begin
    int d0, v0, b0;
    rst_n = 1'b0;
    conf = 1'b0;
    ddr_st_addr = '0;
    ddr_len = '0;
    rd_addr_ready = 1'b0;
    fifo_req = 1'b0;
    repeat (3) tick();
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_burst_len", rd_burst_len, 0);
    chk("rst_addr_valid", rd_addr_valid, 0);
    chk("rst_data_ready", rd_data_ready, 1);
    chk("rst_fifo_empty", fifo_empty, 1);
    chk("rst_fifo_data", fifo_data[63:0], 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_idle", idle, 1);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();
    rd_addr_ready = 1'b1;
    fifo_req = 1'b1;
    clear();
    d0 = done_cnt;
    start(32'h1000, 24'd1280);
    wait_done(d0, "split_done");
    drain();
    chk("split_nreq", req_addr.size(), 3);
    chk_req("split_b0", 0, 32'h1000, 8'd15);
    chk_req("split_b1", 1, 32'h1200, 8'd15);
    chk_req("split_b2", 2, 32'h1400, 8'd7);
    chk_pops("split", 40, 32'h1000);
    chk("split_done_once", done_cnt - d0, 1);
    chk("split_idle", idle, 1);
    clear();
    d0 = done_cnt;
    start(32'h1F80, 24'd512);
    wait_done(d0, "b4k_done");
    drain();
    chk("b4k_nreq", req_addr.size(), 2);
    chk_req("b4k_b0", 0, 32'h1F80, 8'd3);
    chk_req("b4k_b1", 1, 32'h2000, 8'd11);
    chk_pops("b4k", 16, 32'h1F80);
    clear();
    d0 = done_cnt;
    v0 = valid_cnt;
    start(32'h3000, 24'd0);
    chk("len0_done", done, 1);
    chk("len0_idle", idle, 1);
    tick();
    chk("len0_done_pulse", done, 0);
    repeat (5) tick();
    chk("len0_novalid", valid_cnt - v0, 0);
    chk("len0_nreq", req_addr.size(), 0);
    fifo_req = 1'b0;
    clear();
    d0 = done_cnt;
    start(32'h5000, 24'd33);
    chk("lat_e0_idle", idle, 0);
    chk("lat_e0_valid", rd_addr_valid, 0);
    tick();
    chk("lat_e1_valid", rd_addr_valid, 0);
    tick();
    chk("lat_e2_valid", rd_addr_valid, 1);
    chk("len33_addr", rd_addr, 32'h5000);
    chk("len33_blen", rd_burst_len, 1);
    b0 = beats_sent;
    for (int i = 0; i < 50 && beats_sent == b0; i++) tick();
    chk("len33_beat_seen", beats_sent - b0, 1);
    chk("len33_empty_pre", fifo_empty, 1);
    tick();
    chk("len33_empty_n", fifo_empty, 1);
    tick();
    chk("len33_empty_n1", fifo_empty, 0);
    chk("len33_head", fifo_data[31:0], 32'h5000);
    tick();
    chk("len33_count", fifo_count, 2);
    fifo_req = 1'b1;
    wait_done(d0, "len33_done");
    drain();
    chk_pops("len33", 2, 32'h5000);
    rd_addr_ready = 1'b0;
    clear();
    d0 = done_cnt;
    start(32'h4000, 24'd256);
    repeat (4) tick();
    chk("ign_valid", rd_addr_valid, 1);
    ddr_st_addr = 32'h8000;
    ddr_len = 24'd64;
    conf = 1'b1;
    tick();
    conf = 1'b0;
    chk("ign_idle", idle, 0);
    chk("ign_addr_stable", rd_addr, 32'h4000);
    rd_addr_ready = 1'b1;
    wait_done(d0, "ign_done");
    drain();
    chk("ign_nreq", req_addr.size(), 1);
    chk_req("ign_b0", 0, 32'h4000, 8'd7);
    chk_pops("ign", 8, 32'h4000);
    chk("ign_done_once", done_cnt - d0, 1);
    fifo_req = 1'b0;
    clear();
    d0 = done_cnt;
    v0 = valid_cnt;
    start(32'h0, 24'd4096);
    repeat (150) tick();
    chk("bp_nreq", req_addr.size(), 4);
    chk("bp_count", fifo_count, 64);
    chk("bp_valid", rd_addr_valid, 0);
    chk("bp_valid_cycles", valid_cnt - v0, 4);
    fifo_req = 1'b1;
    wait_done(d0, "bp_done");
    drain();
    chk("bp_nreq_total", req_addr.size(), 8);
    chk_pops("bp", 128, 32'h0);
    fifo_req = 1'b0;
    clear();
    b0 = beats_sent;
    start(32'h1000, 24'd1280);
    for (int i = 0; i < 200 && beats_sent - b0 < 10; i++) tick();
    chk("rst_mid_pre_count", fifo_count, 8);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_empty", fifo_empty, 1);
    chk("rst_mid_count", fifo_count, 0);
    chk("rst_mid_valid", rd_addr_valid, 0);
    chk("rst_mid_idle", idle, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 200 && beat_q.size() != 0; i++) tick();
    repeat (3) tick();
    chk("late_empty", fifo_empty, 1);
    chk("late_count", fifo_count, 0);
    chk("late_idle", idle, 1);
    clear();
    fifo_req = 1'b1;
    d0 = done_cnt;
    start(32'h0, 24'd64);
    wait_done(d0, "post_rst_done");
    drain();
    chk("post_rst_nreq", req_addr.size(), 1);
    chk_req("post_rst_b0", 0, 32'h0, 8'd1);
    chk_pops("post_rst", 2, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ddr_weight_reader.md
Name: ddr_weight_reader

Overview:
- DDR read engine directly upstream of the weight-FIFO controller.
- Takes a start address and byte length, splits the transfer into read bursts on a valid/ready memory port, and buffers the returned beats in an internal FIFO.
- Exposes that FIFO as a first-word-fall-through interface (fifo_empty / fifo_req / fifo_data) to the weight-FIFO controller.
- Credit-based issue guarantees the FIFO never overflows.

Parameters:
- DDR_ADDR_LEN, 32, byte-address width
- DDR_DATA_LEN, 256, beat width in bits (beat = 32 bytes)
- SINGLE_LEN, 24, width of the byte-length field
- MAX_BURST, 16, maximum beats per burst (power of 2, ≤256)
- FIFO_DEPTH, 64, beat FIFO depth (power of 2, ≥MAX_BURST)
- MAX_OUTSTANDING, 4, maximum issued-but-incomplete bursts

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- conf  in  1  start pulse; sampled only when idle=1
- ddr_st_addr  in  DDR_ADDR_LEN  start byte address, 32-byte aligned
- ddr_len  in  SINGLE_LEN  transfer length in bytes
- rd_addr  out  DDR_ADDR_LEN  burst byte address
- rd_burst_len  out  8  beats-1
- rd_addr_valid  out  1  burst request valid
- rd_addr_ready  in  1  burst request accepted
- rd_data  in  DDR_DATA_LEN  returned beat
- rd_data_valid  in  1  beat valid
- rd_data_last  in  1  last beat of burst
- rd_data_ready  out  1  beat accepted
- fifo_empty  out  1  no beat available
- fifo_req  in  1  pop
- fifo_data  out  DDR_DATA_LEN  head beat (FWFT)
- fifo_count  out  clog2(FIFO_DEPTH)+1  beats held
- idle  out  1  no transfer in progress
- done  out  1  one-cycle pulse at transfer completion

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. Reset values:
  - rd_addr=0, rd_burst_len=0, rd_addr_valid=0
  - rd_data_ready=1, fifo_empty=1, fifo_data=0, fifo_count=0
  - idle=1, done=0
  - FIFO pointers cleared, all counters cleared.
- Total beats: total_beats = ceil(ddr_len/32), computed in SINGLE_LEN bits. The final partial beat is transferred whole; trailing bytes are don't-care.
- State machine: IDLE → CALC → ISSUE → WAIT → IDLE.
  - IDLE: conf=1 latches ddr_st_addr and total_beats, drops idle, then moves to CALC. If total_beats=0, it goes straight to the completion cycle instead: done=1 next cycle, no request issued, idle stays 1.
  - CALC (1 cycle): computes the next burst size, bl = min(remaining_beats, MAX_BURST, beats_to_4KB_boundary). Bursts never cross a 4 KB address boundary.
  - ISSUE: rd_addr_valid=1 only while both hold:
    - free_credit ≥ bl, where free_credit = FIFO_DEPTH − fifo_count − reserved_beats_outstanding
    - outstanding < MAX_OUTSTANDING
  - ISSUE handshake: rd_addr, rd_burst_len=bl−1 and rd_addr_valid stay stable until rd_addr_ready. On the handshake edge: addr += 32·bl; remaining −= bl; reserved += bl; outstanding += 1. Next state is CALC if remaining>0, else WAIT.
  - WAIT: stays until every issued beat has been received, then done=1 for one cycle, idle=1, return to IDLE.
- Latency: conf at edge 0 → rd_addr_valid high after edge 2.
- Data side:
  - rd_data_ready is held at 1; credit makes acceptance always safe.
  - An accepted beat is pushed and decrements reserved.
  - rd_data_last decrements outstanding.
  - A beat accepted at edge N is visible on fifo_data and fifo_empty=0 after edge N+1 if the FIFO was empty.
- FIFO pop: a pop occurs at each edge with fifo_req=1 && fifo_empty=0; fifo_req while empty is ignored. A simultaneous push and pop leaves fifo_count unchanged. Data order equals arrival order; the memory side returns bursts in order.
- Beats arriving while in IDLE are accepted and discarded (post-reset stragglers).
- conf while idle=0: ignored.
- Reset mid-transfer: returns immediately to reset values and the FIFO is flushed.

Test Plan:
- Burst split: addr=0x1000, len=1280 (40 beats), rd_addr_ready=1 → bursts (0x1000, len 15), (0x1200, 15), (0x1400, 7). 40 beats pop in order; done pulse once; idle=1 after.
- 4 KB crossing: addr=0x1F80, len=512 → bursts (0x1F80, rd_burst_len=3) then (0x2000, rd_burst_len=11).
- Back-pressure: fifo_req=0, len=4096 (128 beats), FIFO_DEPTH=64 → exactly 4 bursts issued, fifo_count=64, no further rd_addr_valid. After fifo_req=1 the remaining 64 beats flow; 128 beats total, no loss or duplication.
- Edge lengths: len=0 → done the cycle after conf, no rd_addr_valid. len=33 → one burst, rd_burst_len=1.
- Reset mid-transfer after 10 of 40 beats → next cycle fifo_empty=1, fifo_count=0, rd_addr_valid=0, idle=1. Late beats are discarded; a new conf works normally.
- conf pulsed during an active transfer → ignored; the current transfer completes unchanged.
